// File: rtl/tm1638_key_reader.sv
// TM1638 key-scan reader: sends read command 0x42, then clocks in four key bytes (byte0 first, LSB first).
// Optional TM1638_KEY_DEBOUNCE_EN: o_Keys only updates when two consecutive raw scans agree.
module tm1638_key_reader #(
    parameter int CLK_DIV     = 4,
    parameter int WAIT_CYCLES = 8
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_Start,
    output logic        o_Busy,
    output logic        o_STB,
    output logic        o_CLK,
    output logic        o_DIO_Out,
    output logic        o_DIO_Oe,
    input  logic        i_DIO,
    output logic [31:0] o_Keys,
    output logic        o_Valid,
    output logic        o_Changed
);

    localparam logic [7:0] CMD_READ = 8'h42;
    // Sized for the longest phase (HOLD = 2*CLK_DIV) or tWAIT, whichever is larger.
    localparam int CNT_MAX = (2 * CLK_DIV > WAIT_CYCLES) ? 2 * CLK_DIV : WAIT_CYCLES;
    localparam int DIV_W   = $clog2(CNT_MAX + 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] HOLD_LAST = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0] WAIT_LAST = DIV_W'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_CMD, S_WAIT, S_READ, S_END, S_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [4:0]         bit_q, bit_d;
    logic               phase_q, phase_d;
    logic [31:0]        shift_q, shift_d;
    logic [31:0]        keys_q, keys_d;
    logic               valid_q, valid_d;
    logic               changed_q, changed_d;
    logic               stb_q, stb_d;
    logic               clk_q, clk_d;
    logic               dio_out_q, dio_out_d;
    logic               dio_oe_q, dio_oe_d;
    logic               busy_q, busy_d;
    logic               commit;
`ifdef TM1638_KEY_DEBOUNCE_EN
    logic [31:0]        prev_q, prev_d;
`endif

    always_comb begin
        state_d   = state_q;
        div_d     = div_q + DIV_W'(1);
        bit_d     = bit_q;
        phase_d   = phase_q;
        shift_d   = shift_q;
        commit    = 1'b0;
        case (state_q)
            S_IDLE: begin
                div_d = '0;
                if (i_Start) state_d = S_SETUP;
            end
            S_SETUP: begin
                if (div_q == DIV_LAST) begin
                    state_d = S_CMD;
                    div_d   = '0;
                    bit_d   = '0;
                    phase_d = 1'b0;
                end
            end
            // phase_q: 0 = CLK low half, 1 = CLK high half of the current bit
            S_CMD, S_READ: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        if (state_q == S_READ) shift_d = {i_DIO, shift_q[31:1]};
                        phase_d = 1'b0;
                        bit_d   = bit_q + 5'd1;
                        if (state_q == S_CMD && bit_q == 5'd7) begin
                            state_d = S_WAIT;
                            bit_d   = '0;
                        end
                        if (state_q == S_READ && bit_q == 5'd31) begin
                            state_d = S_END;
                            bit_d   = '0;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (div_q == WAIT_LAST) begin
                    state_d = S_READ;
                    div_d   = '0;
                    bit_d   = '0;
                    phase_d = 1'b0;
                end
            end
            S_END: begin
                if (div_q == DIV_LAST) begin
                    state_d = S_HOLD;
                    div_d   = '0;
                    commit  = 1'b1;
                end
            end
            S_HOLD: begin
                if (div_q == HOLD_LAST) begin
                    state_d = S_IDLE;
                    div_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        keys_d    = keys_q;
        changed_d = 1'b0;
        valid_d   = commit;
`ifdef TM1638_KEY_DEBOUNCE_EN
        prev_d    = prev_q;
        if (commit) begin
            prev_d = shift_q;
            if (shift_q == prev_q) begin
                keys_d    = shift_q;
                changed_d = (shift_q != keys_q);
            end
        end
`else
        if (commit) begin
            keys_d    = shift_q;
            changed_d = (shift_q != keys_q);
        end
`endif
    end

    // Pin outputs are decoded from the next state so they are registered yet aligned with it.
    always_comb begin
        busy_d    = (state_d != S_IDLE);
        stb_d     = (state_d == S_IDLE) || (state_d == S_HOLD);
        clk_d     = !(((state_d == S_CMD) || (state_d == S_READ)) && !phase_d);
        dio_oe_d  = (state_d == S_CMD);
        dio_out_d = (state_d == S_CMD) ? CMD_READ[bit_d[2:0]] : 1'b1;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            phase_q   <= 1'b0;
            shift_q   <= '0;
            keys_q    <= '0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            stb_q     <= 1'b1;
            clk_q     <= 1'b1;
            dio_out_q <= 1'b1;
            dio_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            phase_q   <= phase_d;
            shift_q   <= shift_d;
            keys_q    <= keys_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
            stb_q     <= stb_d;
            clk_q     <= clk_d;
            dio_out_q <= dio_out_d;
            dio_oe_q  <= dio_oe_d;
            busy_q    <= busy_d;
        end
    end

`ifdef TM1638_KEY_DEBOUNCE_EN
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) prev_q <= '0;
        else          prev_q <= prev_d;
    end
`endif

    assign o_Busy    = busy_q;
    assign o_STB     = stb_q;
    assign o_CLK     = clk_q;
    assign o_DIO_Out = dio_out_q;
    assign o_DIO_Oe  = dio_oe_q;
    assign o_Keys    = keys_q;
    assign o_Valid   = valid_q;
    assign o_Changed = changed_q;

endmodule
